msk_roundcst_gen: RTL and testbench
===================================

Name: msk_roundcst_gen

Overview:
- Sequencer that produces the masked round constant consumed by the masked constant-addition layer of the Ascon permutation.
- On a start request it steps through the 12, 8 or 6 round constants of p^a / p^b.
- Each constant is freshly re-shared, then presented to the permutation datapath one round at a time under a valid/advance handshake.
- Sits in the masked permutation controller, upstream of the constant-addition layer's roundcst input.

Parameters:
- d, 2, number of shares (d >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a permutation run; sampled only in IDLE.
- nrounds  input  2  round count: 00 -> 12, 01 -> 8, 10 -> 6, 11 -> 12.
- adv  input  1  permutation has consumed the current constant; advance.
- rnd  input  8*(d-1)  fresh randomness for re-sharing, sampled on the load edges.
- roundcst  output  8*d  masked constant. Share-interleaved: share j of bit i is at index i*d+j.
- cst_valid  output  1  roundcst holds a live constant.
- last  output  1  current constant is the final round (index 11).
- round_idx  output  4  current round index, 0..11.
- busy  output  1  high from the start acceptance edge until done.
- done  output  1  one-cycle pulse after the final round is consumed.

Behaviour:
- Constant for index r: (((15-r) mod 16) << 4) | r, giving f0, e1, d2, c3, b4, a5, 96, 87, 78, 69, 5a, 4b.
- Start index s = 12 - N: 0, 4 or 6.
- Masking: shares 1..d-1 of bit i = rnd[i*(d-1)+j-1]. Share 0 = constant bit XOR all other shares of that bit.
- Masking check: the XOR of all shares always equals the constant.
- FSM states: IDLE, RUN, FIN.
- IDLE: cst_valid=0, busy=0, last=0, done=0, roundcst=0, round_idx=0.
  - start=1 -> RUN on the next edge, with round_idx=s.
  - roundcst is loaded on that same edge from rnd.
- RUN: cst_valid=1, busy=1, last=(round_idx==11).
  - adv=1 and round_idx<11 -> round_idx+1, roundcst re-shared with the rnd of that edge; stay in RUN.
  - adv=1 and round_idx==11 -> FIN; cst_valid=0 and roundcst=0 next cycle.
  - adv=0 -> all outputs hold; no re-sharing.
- FIN: done=1, busy=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - start edge to first cst_valid: 1 cycle.
  - With adv held high, 12 rounds give cst_valid for 12 cycles; done is asserted in cycle 13 after start.
- Boundaries:
  - start in RUN or FIN is ignored; no queueing.
  - adv in IDLE or FIN is ignored.
  - nrounds is sampled only on the start edge; changes during RUN have no effect.
- rst: every state register returns to the IDLE values on the next edge, including mid-RUN. No done pulse is issued for an aborted run.
- All outputs are registered; no combinational path from rnd or adv to roundcst.

Decomposition:
- Package ascon_msk_pkg holds:
  - the 2-bit round-count encodings;
  - start-index constants (0, 4, 6);
  - the unmasked constant function of r;
  - the FSM state enum.
- Sub-module msk_cst_share (combinational, parameter d): takes the 8-bit constant and rnd and returns the interleaved 8*d-bit sharing.
  - The FSM instantiates it once and registers its output.

Test Plan:
- d=2, rnd=00, nrounds=00, start, adv always 1:
  - first roundcst=0x5500 (f0, share1=0);
  - round_idx runs 0..11;
  - last only with 4b;
  - done in cycle 13.
- d=2, rnd=ff, nrounds=00: first roundcst=0xAAFF. Shares unmasked XOR to f0; share1 is all ones.
- nrounds=01 and nrounds=10 with random rnd:
  - unmasked sequences are b4..4b (8 values) and 96..4b (6 values);
  - done follows 8 and 6 consumed rounds respectively.
- adv stalled for 5 cycles mid-run while rnd toggles: roundcst and round_idx hold; the next constant appears only after adv.
- start pulsed during RUN and adv pulsed in IDLE: no state change.
- rst asserted at round_idx=7: next cycle shows IDLE values with no done pulse; a new start then works from index 0.

Source files
------------

// File: rtl/ascon_msk_pkg.sv
// ascon_msk_pkg
// Shared definitions for the masked Ascon round-constant sequencer:
//   - 2-bit round-count encodings on the nrounds input
//   - first round index for each round count (12 - N)
//   - unmasked round constant as a function of the round index
//   - sequencer FSM state encoding
package ascon_msk_pkg;

    // nrounds encodings; 2'b11 is an alias for the full 12-round run
    localparam logic [1:0] NR_12     = 2'b00;
    localparam logic [1:0] NR_8      = 2'b01;
    localparam logic [1:0] NR_6      = 2'b10;
    localparam logic [1:0] NR_12_ALT = 2'b11;

    // First round index for each run length; all runs end on index 11
    localparam logic [3:0] START_IDX_12 = 4'd0;
    localparam logic [3:0] START_IDX_8  = 4'd4;
    localparam logic [3:0] START_IDX_6  = 4'd6;
    localparam logic [3:0] LAST_IDX     = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    // Upper nibble counts down from 15 while the lower nibble counts up
    function automatic logic [7:0] round_const(input logic [3:0] r);
        logic [3:0] hi;
        hi = 4'd15 - r;
        return {hi, r};
    endfunction

    function automatic logic [3:0] start_index(input logic [1:0] nr);
        logic [3:0] s;
        case (nr)
            NR_8:    s = START_IDX_8;
            NR_6:    s = START_IDX_6;
            default: s = START_IDX_12;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/msk_cst_share.sv
// msk_cst_share
// Combinational d-share Boolean masking of an 8-bit constant.
// Ports:
//   cst_i      [7:0]          unmasked constant
//   rnd_i      [8*(d-1)-1:0]  fresh randomness, d-1 bits per constant bit
//   shares_o   [8*d-1:0]      share-interleaved result: share j of bit i
//                             sits at index i*d+j
// Shares 1..d-1 are taken straight from the randomness; share 0 absorbs
// the constant so that the XOR over all shares of a bit equals that bit.
module msk_cst_share #(
    parameter int d = 2
) (
    input  logic [7:0]         cst_i,
    input  logic [8*(d-1)-1:0] rnd_i,
    output logic [8*d-1:0]     shares_o
);

    always_comb begin
        logic acc;
        shares_o = '0;
        for (int i = 0; i < 8; i++) begin
            acc = cst_i[i];
            for (int j = 1; j < d; j++) begin
                shares_o[i*d+j] = rnd_i[i*(d-1)+j-1];
                acc = acc ^ rnd_i[i*(d-1)+j-1];
            end
            shares_o[i*d] = acc;
        end
    end

endmodule

// File: rtl/msk_roundcst_gen.sv
// msk_roundcst_gen
// Sequencer producing the masked round constant for the masked Ascon
// constant-addition layer. A start request in IDLE launches a run of
// 12, 8 or 6 rounds; each constant is freshly re-shared when it is loaded
// and held until the permutation signals adv.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      run request, sampled only in IDLE
//   nrounds    round count select (00/11 -> 12, 01 -> 8, 10 -> 6)
//   adv        current constant consumed, advance to the next one
//   rnd        re-sharing randomness, used on load edges only
//   roundcst   masked constant, share-interleaved (bit i share j at i*d+j)
//   cst_valid  roundcst holds a live constant
//   last       current constant is round index 11
//   round_idx  current round index
//   busy       run in progress (RUN or FIN)
//   done       one-cycle pulse after the final constant is consumed
module msk_roundcst_gen
    import ascon_msk_pkg::*;
#(
    parameter int d = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         nrounds,
    input  logic               adv,
    input  logic [8*(d-1)-1:0] rnd,
    output logic [8*d-1:0]     roundcst,
    output logic               cst_valid,
    output logic               last,
    output logic [3:0]         round_idx,
    output logic               busy,
    output logic               done
);

    state_e           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [8*d-1:0]   cst_q, cst_d;

    // Constant fed to the single sharing instance: whichever round is
    // about to be loaded on this edge.
    logic [7:0]       cstSel;
    logic [8*d-1:0]   sharedCst;

    msk_cst_share #(.d(d)) u_share (
        .cst_i    (cstSel),
        .rnd_i    (rnd),
        .shares_o (sharedCst)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cst_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cst_q   <= cst_d;
        end
    end

    // Index and masked constant are cleared whenever the sequencer leaves
    // RUN so that IDLE and FIN present all-zero data.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cst_d   = cst_q;
        cstSel  = round_const(idx_q);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = start_index(nrounds);
                    cstSel  = round_const(start_index(nrounds));
                    cst_d   = sharedCst;
                end
            end
            ST_RUN: begin
                if (adv) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FIN;
                        idx_d   = '0;
                        cst_d   = '0;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        cstSel  = round_const(idx_q + 4'd1);
                        cst_d   = sharedCst;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cst_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cst_d   = '0;
            end
        endcase
    end

    // Outputs decode flops only, so rnd and adv never reach them
    // combinationally.
    assign roundcst  = cst_q;
    assign round_idx = idx_q;
    assign cst_valid = (state_q == ST_RUN);
    assign last      = (state_q == ST_RUN) && (idx_q == LAST_IDX);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_FIN);
    assign done      = (state_q == ST_FIN);

endmodule

// File: tb/tb_msk_roundcst_gen.sv
// tb_msk_roundcst_gen
// Directed checks of the masked round-constant sequencer with d = 2.
module tb_msk_roundcst_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  nrounds;
    logic        adv;
    logic [7:0]  rnd;
    logic [15:0] roundcst;
    logic        cst_valid;
    logic        last;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int vecCount;
    int missCount;

    // Hand-listed round constants for index 0..11
    logic [7:0] cstTab [0:11] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                  8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    msk_roundcst_gen #(.d(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .nrounds   (nrounds),
        .adv       (adv),
        .rnd       (rnd),
        .roundcst  (roundcst),
        .cst_valid (cst_valid),
        .last      (last),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the sequencer wedges
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "[TB] watchdog");
    end

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] nr, input logic a, input logic [7:0] r);
        start   = s;
        nrounds = nr;
        adv     = a;
        rnd     = r;
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected d=2 sharing: share1 = rnd bit, share0 = constant ^ rnd bit
    function automatic logic [15:0] expShare(input logic [7:0] c, input logic [7:0] r);
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            e[2*i+1] = r[i];
            e[2*i]   = c[i] ^ r[i];
        end
        return e;
    endfunction

    function automatic logic [7:0] unmask(input logic [15:0] rc);
        logic [7:0] u;
        for (int i = 0; i < 8; i++) u[i] = rc[2*i] ^ rc[2*i+1];
        return u;
    endfunction

    function automatic int firstIdx(input logic [1:0] nr);
        if (nr == 2'b01) return 4;
        if (nr == 2'b10) return 6;
        return 0;
    endfunction

    task automatic checkRound(input int k, input logic [7:0] r);
        checkOutput("round_idx", 32'(round_idx), 32'(k));
        checkOutput("cst_valid", 32'(cst_valid), 32'd1);
        checkOutput("busy_run",  32'(busy), 32'd1);
        checkOutput("done_run",  32'(done), 32'd0);
        checkOutput("last",      32'(last), (k == 11) ? 32'd1 : 32'd0);
        checkOutput("roundcst",  32'(roundcst), 32'(expShare(cstTab[k], r)));
        checkOutput("unmasked",  32'(unmask(roundcst)), 32'(cstTab[k]));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, 32'(cst_valid), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "_done"},  32'(done), 32'd0);
        checkOutput({tag, "_last"},  32'(last), 32'd0);
        checkOutput({tag, "_idx"},   32'(round_idx), 32'd0);
        checkOutput({tag, "_cst"},   32'(roundcst), 32'd0);
    endtask

    // Expects the sequencer to be in FIN now, then IDLE one cycle later
    task automatic checkFin();
        checkOutput("fin_done",  32'(done), 32'd1);
        checkOutput("fin_busy",  32'(busy), 32'd1);
        checkOutput("fin_valid", 32'(cst_valid), 32'd0);
        checkOutput("fin_cst",   32'(roundcst), 32'd0);
        tick();
        checkIdle("post_fin");
    endtask

    // Full run with adv held high. nrounds is scrambled after the start
    // edge to show it is only sampled once.
    task automatic runFull(input logic [1:0] nr, input bit useRand, input logic [7:0] fixRnd,
                           input bit chkFirst, input logic [15:0] firstExp);
        logic [7:0] r;
        r = useRand ? 8'($urandom) : fixRnd;
        applyStimulus(1'b1, nr, 1'b1, r);
        tick();
        start   = 1'b0;
        nrounds = ~nr;
        if (chkFirst) checkOutput("first_cst", 32'(roundcst), 32'(firstExp));
        for (int k = firstIdx(nr); k < 12; k++) begin
            checkRound(k, r);
            r   = useRand ? 8'($urandom) : fixRnd;
            rnd = r;
            tick();
        end
        checkFin();
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] held;
        vecCount  = 0;
        missCount = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        checkIdle("reset");

        // 12 rounds, zero randomness, then all-ones randomness
        runFull(2'b00, 1'b0, 8'h00, 1'b1, 16'h5500);
        runFull(2'b00, 1'b0, 8'hff, 1'b1, 16'hAAFF);

        // Short runs with random re-sharing, plus the 11 alias
        runFull(2'b01, 1'b1, 8'h00, 1'b0, 16'h0000);
        runFull(2'b10, 1'b1, 8'h00, 1'b0, 16'h0000);
        runFull(2'b11, 1'b1, 8'h00, 1'b0, 16'h0000);

        // Stall at index 3 for 5 cycles while rnd toggles and start pulses
        r = 8'h5c;
        applyStimulus(1'b1, 2'b00, 1'b1, r);
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkRound(k, r);
            r   = 8'($urandom);
            rnd = r;
            tick();
        end
        checkRound(3, r);
        held = r;
        adv  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rnd   = (c % 2 == 0) ? 8'hff : 8'h00;
            start = (c == 2);
            tick();
            start = 1'b0;
            checkRound(3, held);
        end
        r   = 8'ha7;
        rnd = r;
        adv = 1'b1;
        tick();
        for (int k = 4; k < 12; k++) begin
            checkRound(k, r);
            r   = 8'($urandom);
            rnd = r;
            tick();
        end
        checkFin();

        // adv in IDLE has no effect
        applyStimulus(1'b0, 2'b00, 1'b1, 8'h3c);
        tick();
        tick();
        checkIdle("adv_idle");

        // Reset at index 7 aborts without a done pulse
        r = 8'h11;
        applyStimulus(1'b1, 2'b00, 1'b1, r);
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checkRound(k, r);
            r   = 8'($urandom);
            rnd = r;
            tick();
        end
        checkRound(7, r);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkIdle("abort");
        tick();
        checkIdle("abort_next");

        // Fresh start after the abort begins at index 0
        runFull(2'b00, 1'b1, 8'h00, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
